// File: rtl/dma_rd_pkg.sv
// Shared definitions for the DMA read burst sequencer.
// Contents: default widths, beat size helpers, 4 KB page constants, FSM state encoding.
package dma_rd_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 256;
  localparam int unsigned LEN_W_DEF   = 8;
  localparam int unsigned CNT_W_DEF   = 20;
  localparam int unsigned FIFO_AW_DEF = 6;

  localparam int unsigned BYTES      = DATA_W_DEF / 8;
  localparam int unsigned BYTES_LOG2 = $clog2(BYTES);

  localparam int unsigned PAGE_SIZE  = 4096;
  localparam int unsigned PAGE_OFS_W = 12;

  // log2 of the beat size in bytes for a given data width
  function automatic int unsigned bytes_log2(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DATA  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/dma_rd_burst_seq_if.sv
// Bus bundle between the burst sequencer, the AXI DMA read engine and the stream consumer.
// dma_valid/dma_addr/dma_len : burst request to the engine
// dma_ready/dma_rdata        : engine beat strobe and read data
// m_valid/m_data/m_ready     : show-ahead output stream
// master = sequencer side, slave = engine/consumer side.
interface dma_rd_burst_seq_if #(
  parameter int unsigned ADDR_W = dma_rd_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = dma_rd_pkg::DATA_W_DEF,
  parameter int unsigned LEN_W  = dma_rd_pkg::LEN_W_DEF
) ();

  logic              dma_valid;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_ready;
  logic [DATA_W-1:0] dma_rdata;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    output dma_valid, dma_addr, dma_len,
    input  dma_ready, dma_rdata,
    output m_valid, m_data,
    input  m_ready
  );

  modport slave (
    input  dma_valid, dma_addr, dma_len,
    output dma_ready, dma_rdata,
    input  m_valid, m_data,
    output m_ready
  );

endinterface

// File: rtl/dma_rd_fifo.sv
// Synchronous show-ahead FIFO holding returned read beats.
// Ports: clk, rst_n, push/wdata (write), pop (read ack), rdata (head), empty, full,
//        count (occupancy, FIFO_AW+1 bits). A push while full is dropped unless a pop
//        happens in the same cycle.
module dma_rd_fifo #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned FIFO_AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic [FIFO_AW:0]  count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_rd_burst_seq.sv
// Upstream sequencer for the AXI DMA read engine: splits one read job into bursts,
// issues a burst only when the local FIFO can absorb all of its beats, and streams
// the returned beats out as valid/ready.
// Ports: clk, rst_n (async active-low); cfg_start/cfg_addr/cfg_beats/cfg_burst_len job
//        setup; busy, done (one-cycle), overflow (sticky); bus (master modport) carries
//        the engine request/data port and the output stream.
// Build option: DMA_RD_4K_SPLIT_EN keeps every burst inside one 4 KB page.
module dma_rd_burst_seq
  import dma_rd_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned FIFO_AW = FIFO_AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [CNT_W-1:0]   cfg_beats,
  input  logic [LEN_W-1:0]   cfg_burst_len,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  dma_rd_burst_seq_if.master bus
);

  localparam int unsigned BW     = LEN_W + 1;
  localparam int unsigned MW     = 32;
  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned SHIFT  = bytes_log2(DATA_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  blen_q, blen_d;
  logic [BW-1:0]     beats_q, beats_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              busy_d, done_d, ovf_d;
  logic              dma_valid_q, dma_valid_d;
  logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
  logic [LEN_W-1:0]  dma_len_q, dma_len_d;

  logic [BW-1:0]     beats_c;
  logic [MW-1:0]     lim;
  logic [FIFO_AW:0]  occ;
  logic [FIFO_AW:0]  free_c;
  logic              fits_c;
  logic              fifo_empty, fifo_full, pop_c;
  logic [DATA_W-1:0] fifo_rdata;

  dma_rd_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.dma_ready),
    .wdata (bus.dma_rdata),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (occ)
  );

  assign bus.m_valid   = !fifo_empty;
  assign bus.m_data    = fifo_rdata;
  assign pop_c         = !fifo_empty && bus.m_ready;
  assign bus.dma_valid = dma_valid_q;
  assign bus.dma_addr  = dma_addr_q;
  assign bus.dma_len   = dma_len_q;

  // Free space must cover the whole burst: the engine cannot be stalled mid-burst
  assign free_c = (FIFO_AW+1)'(DEPTH) - occ;
  assign fits_c = (MW'(free_c) >= MW'(beats_q));

`ifdef DMA_RD_4K_SPLIT_EN
  localparam int unsigned PW = PAGE_OFS_W + 1;
  logic [PW-1:0] page_left;
  logic [PW-1:0] page_beats;
  assign page_left  = PW'(PAGE_SIZE) - PW'(addr_q[PAGE_OFS_W-1:0]);
  assign page_beats = page_left >> SHIFT;
`endif

  // Burst size: smallest of remaining beats, programmed max and (optionally) page room
  always_comb begin
    lim = MW'(rem_q);
    if (MW'(blen_q) + MW'(1) < lim) lim = MW'(blen_q) + MW'(1);
`ifdef DMA_RD_4K_SPLIT_EN
    if (MW'(page_beats) < lim) lim = MW'(page_beats);
`endif
    beats_c = BW'(lim);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    blen_d      = blen_q;
    beats_d     = beats_q;
    cnt_d       = cnt_q;
    dma_valid_d = dma_valid_q;
    dma_addr_d  = dma_addr_q;
    dma_len_d   = dma_len_q;
    ovf_d       = overflow | (bus.dma_ready & fifo_full & ~pop_c);

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          addr_d  = cfg_addr;
          rem_d   = cfg_beats;
          blen_d  = cfg_burst_len;
          state_d = (cfg_beats == '0) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        beats_d = beats_c;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (fits_c) begin
          dma_valid_d = 1'b1;
          dma_addr_d  = addr_q;
          dma_len_d   = LEN_W'(beats_q - BW'(1));
          cnt_d       = '0;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.dma_ready) begin
          // Drop the request on the first beat so the engine never sees it twice
          dma_valid_d = 1'b0;
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_q == dma_len_q) begin
            addr_d  = addr_q + (ADDR_W'(beats_q) << SHIFT);
            rem_d   = rem_q - CNT_W'(beats_q);
            state_d = (rem_q == CNT_W'(beats_q)) ? ST_FIN : ST_CALC;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CALC) || (state_d == ST_ISSUE) || (state_d == ST_DATA);
    done_d = (state_d == ST_FIN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      blen_q      <= '0;
      beats_q     <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      dma_valid_q <= 1'b0;
      dma_addr_q  <= '0;
      dma_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      blen_q      <= blen_d;
      beats_q     <= beats_d;
      cnt_q       <= cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      overflow    <= ovf_d;
      dma_valid_q <= dma_valid_d;
      dma_addr_q  <= dma_addr_d;
      dma_len_q   <= dma_len_d;
    end
  end

endmodule

// File: tb/tb_dma_rd_burst_seq.sv
// Self-checking bench for dma_rd_burst_seq: a read-engine responder returns randomly
// spaced beats tagged with their byte address, a consumer drains the stream, and a
// job-level model predicts the burst list and the beat order.
module tb_dma_rd_burst_seq;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_addr;
  logic [19:0] cfg_beats;
  logic [7:0]  cfg_burst_len;
  logic        busy, done, overflow;

  dma_rd_burst_seq_if #(.ADDR_W(32), .DATA_W(256), .LEN_W(8)) bus ();

  dma_rd_burst_seq #(
    .ADDR_W(32), .DATA_W(256), .LEN_W(8), .CNT_W(20), .FIFO_AW(6)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_addr      (cfg_addr),
    .cfg_beats     (cfg_beats),
    .cfg_burst_len (cfg_burst_len),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  req_t         exp_req[$];
  logic [255:0] exp_data[$];
  int tests = 0;
  int fails = 0;
  int issued = 0;
  int done_cnt = 0;
  int cons_mode = 0;
  int pop_budget = 0;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Job model: expected burst list from the splitting rules
  task automatic model_job(input logic [31:0] a, input int n, input int bl);
    logic [31:0] ad;
    int rem, b;
    ad = a;
    rem = n;
    while (rem > 0) begin
      b = (rem < bl + 1) ? rem : bl + 1;
`ifdef DMA_RD_4K_SPLIT_EN
      if ((4096 - int'(ad[11:0])) / 32 < b) b = (4096 - int'(ad[11:0])) / 32;
`endif
      exp_req.push_back({ad, 8'(b - 1)});
      ad = ad + 32'(b * 32);
      rem -= b;
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Read engine responder
  initial begin
    logic [31:0]  ra;
    logic [7:0]   rl;
    logic [255:0] d;
    req_t er;
    int beat;
    bit ab, vchk;
    bus.dma_ready = 1'b0;
    bus.dma_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.dma_valid) begin
        ra = bus.dma_addr;
        rl = bus.dma_len;
        issued++;
        if (exp_req.size() == 0) er = '1;
        else er = exp_req.pop_front();
        chki("req_addr", int'(ra), int'(er.addr));
        chki("req_len", int'(rl), int'(er.len));
        beat = 0;
        ab = 0;
        vchk = 1;
        while (beat <= int'(rl) && !ab) begin
          if ($urandom_range(0, 3) != 0) begin
            chkb("req_stable", (bus.dma_addr === ra) && (bus.dma_len === rl), 1'b1);
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 ra + 32'(beat * 32)};
            bus.dma_rdata = d;
            bus.dma_ready = 1'b1;
            exp_data.push_back(d);
            beat++;
          end
          @(posedge clk);
          #1;
          bus.dma_ready = 1'b0;
          if (!rst_n) ab = 1;
          else if (beat == 1 && vchk) begin
            chkb("valid_clr", bus.dma_valid, 1'b0);
            vchk = 0;
          end
        end
      end
    end
  end

  // Stream consumer
  initial begin
    logic [255:0] ed;
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (cons_mode)
        1:       bus.m_ready = ($urandom_range(0, 1) == 1);
        2:       bus.m_ready = 1'b1;
        3:       bus.m_ready = (pop_budget > 0);
        default: bus.m_ready = 1'b0;
      endcase
      if (rst_n && bus.m_ready && bus.m_valid) begin
        if (exp_data.size() == 0) ed = '1;
        else ed = exp_data.pop_front();
        chkw("m_data", bus.m_data, ed);
        if (cons_mode == 3) pop_budget--;
      end
    end
  end

  // done pulse counter
  initial forever begin
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  task automatic start_job(input logic [31:0] a, input int n, input int bl);
    model_job(a, n, bl);
    cfg_addr      = a;
    cfg_beats     = 20'(n);
    cfg_burst_len = 8'(bl);
    cfg_start     = 1'b1;
    step();
    cfg_start     = 1'b0;
  endtask

  task automatic finish_job(input int d0);
    int cyc;
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      step();
      cyc++;
    end
    chki("done_seen", done_cnt, d0 + 1);
    cyc = 0;
    while ((exp_data.size() != 0 || bus.m_valid) && cyc < 20000) begin
      step();
      cyc++;
    end
    chki("drained", exp_data.size(), 0);
    chki("reqs_left", exp_req.size(), 0);
    chki("done_once", done_cnt, d0 + 1);
    chkb("busy_end", busy, 1'b0);
    chkb("ovf_end", overflow, 1'b0);
  endtask

  task automatic run_job(input logic [31:0] a, input int n, input int bl);
    int d0;
    d0 = done_cnt;
    cons_mode = 1;
    start_job(a, n, bl);
    finish_job(d0);
  endtask

  initial begin
    int d0, i0, cyc;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_addr = '0;
    cfg_beats = '0;
    cfg_burst_len = '0;
    step(2);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_dma_valid", bus.dma_valid, 1'b0);
    chki("rst_dma_addr", int'(bus.dma_addr), 0);
    chki("rst_dma_len", int'(bus.dma_len), 0);
    chkb("rst_m_valid", bus.m_valid, 1'b0);
    chkb("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    step(2);

    run_job(32'h0000_0000, 40, 15);
    run_job(32'h0000_0FC0, 8, 15);

    // empty job
    d0 = done_cnt;
    cfg_beats = '0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chkb("empty_done", done, 1'b1);
    chkb("empty_busy", busy, 1'b0);
    chkb("empty_valid", bus.dma_valid, 1'b0);
    step();
    chkb("empty_done_drop", done, 1'b0);
    chkb("empty_valid2", bus.dma_valid, 1'b0);
    chki("empty_done_cnt", done_cnt, d0 + 1);

    // FIFO-full stall
    cons_mode = 0;
    i0 = issued;
    d0 = done_cnt;
    start_job(32'h0001_0000, 96, 15);
    cyc = 0;
    while (exp_data.size() < 64 && cyc < 2000) begin
      step();
      cyc++;
    end
    step(20);
    chki("stall_bursts", issued - i0, 4);
    chkb("stall_valid", bus.dma_valid, 1'b0);
    chkb("stall_m_valid", bus.m_valid, 1'b1);
    chkb("stall_busy", busy, 1'b1);
    cons_mode = 3;
    pop_budget = 15;
    step(30);
    chki("stall_15pops", issued - i0, 4);
    chkb("stall_valid15", bus.dma_valid, 1'b0);
    pop_budget = 1;
    cyc = 0;
    while (issued - i0 < 5 && cyc < 50) begin
      step();
      cyc++;
    end
    chki("stall_16pops", issued - i0, 5);
    chkb("stall_ovf", overflow, 1'b0);
    cons_mode = 1;
    finish_job(d0);

    // cfg_start while busy is ignored
    d0 = done_cnt;
    cons_mode = 1;
    start_job(32'h0000_2000, 50, 7);
    step(10);
    cfg_addr = 32'hDEAD_0000;
    cfg_beats = 20'd5;
    cfg_burst_len = 8'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chkb("restart_busy", busy, 1'b1);
    finish_job(d0);

    // reset mid-burst
    i0 = issued;
    cons_mode = 1;
    start_job(32'h0000_3000, 64, 15);
    cyc = 0;
    while (issued == i0 && cyc < 200) begin
      step();
      cyc++;
    end
    step(3);
    rst_n = 1'b0;
    #1;
    chkb("mid_rst_valid", bus.dma_valid, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_done", done, 1'b0);
    chkb("mid_rst_m_valid", bus.m_valid, 1'b0);
    exp_req.delete();
    exp_data.delete();
    step(2);
    rst_n = 1'b1;
    step();
    chkb("post_rst_m_valid", bus.m_valid, 1'b0);
    chkb("post_rst_valid", bus.dma_valid, 1'b0);
    run_job(32'h0000_1F00, 20, 3);

    // full-depth bursts and random jobs
    run_job(32'h0000_0F00, 130, 63);
    for (int k = 0; k < 4; k++) begin
      run_job($urandom & 32'hFFFF_FFE0, int'($urandom_range(1, 120)),
              int'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
